uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of the UART receiver. Captures each byte from the

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT byte FIFO with sticky overrun/break
// flags, a registered fill-threshold interrupt and an idle-timeout interrupt.
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int TO_W   = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_break,
   input  logic              rd_en,
   input  logic              flush,
   input  logic              clr_flags,
   input  logic [ADDR_W:0]   thresh,
   input  logic [TO_W-1:0]   to_limit,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_avail,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              overrun,
   output logic              break_det,
   output logic              irq_thresh,
   output logic              irq_timeout
);

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LVL_ONE = 1;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [TO_W-1:0]   TO_ONE  = 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              overrun_q, overrun_d;
   logic              break_q, break_d;
   logic              irq_thresh_q, irq_thresh_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

   logic push_req, pop_ok, is_full, do_push, do_pop, drop;

   assign push_req = rx_valid && !rx_break;
   assign is_full  = (level_q == DEPTH_L);
   assign pop_ok   = rd_en && (level_q != '0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
   assign do_pop   = pop_ok && !flush;
   assign do_push  = push_req && !flush && (!is_full || pop_ok);
   assign drop     = push_req && !flush && is_full && !pop_ok;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      overrun_d = overrun_q;
      break_d   = break_q;
      to_cnt_d  = to_cnt_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
         else if (do_pop && !do_push) level_d = level_q - LVL_ONE;
      end

      if (clr_flags) begin
         overrun_d = 1'b0;
         break_d   = 1'b0;
      end
      // Setting events take priority over a same-cycle clear.
      if (drop)                  overrun_d = 1'b1;
      if (rx_valid && rx_break)  break_d   = 1'b1;

      if (do_push || do_pop || flush || level_q == '0)
         to_cnt_d = '0;
      else if (to_cnt_q < to_limit)
         to_cnt_d = to_cnt_q + TO_ONE;

      irq_thresh_d = (thresh != '0) && (level_d >= thresh);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         overrun_q    <= 1'b0;
         break_q      <= 1'b0;
         irq_thresh_q <= 1'b0;
         to_cnt_q     <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         overrun_q    <= overrun_d;
         break_q      <= break_d;
         irq_thresh_q <= irq_thresh_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= rx_data;
   end

   assign rd_data     = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign rd_avail    = (level_q != '0);
   assign full        = is_full;
   assign level       = level_q;
   assign overrun     = overrun_q;
   assign break_det   = break_q;
   assign irq_thresh  = irq_thresh_q;
   assign irq_timeout = (to_limit != '0) && (level_q != '0) && (to_cnt_q == to_limit);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes are queued as pushes are driven
// and compared against rd_data as the bench pops them.
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        resetn;
   logic        rx_valid, rx_break, rd_en, flush, clr_flags;
   logic [7:0]  rx_data;
   logic [4:0]  thresh;
   logic [15:0] to_limit;
   logic [7:0]  rd_data;
   logic        rd_avail, full, overrun, break_det, irq_thresh, irq_timeout;
   logic [4:0]  level;

   int total = 0;
   int bad   = 0;
   logic [7:0] sb[$];
   logic [7:0] got, exp;

   uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .TO_W(16)) dut (
      .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_break(rx_break), .rd_en(rd_en), .flush(flush), .clr_flags(clr_flags),
      .thresh(thresh), .to_limit(to_limit), .rd_data(rd_data), .rd_avail(rd_avail),
      .full(full), .level(level), .overrun(overrun), .break_det(break_det),
      .irq_thresh(irq_thresh), .irq_timeout(irq_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b;
      if (sb.size() < 16) sb.push_back(b);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic pop_byte(output logic [7:0] d);
      d = rd_data;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      tick();
      total++; if (level !== 5'd0 || rd_avail !== 1'b0 || rd_data !== 8'h00) begin
         bad++; $display("FAIL reset_init level=%0d avail=%b data=%h want 0/0/00", level, rd_avail, rd_data); end
      for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
      total++; if (level !== 5'd5) begin
         bad++; $display("FAIL reset_prefill level=%0d want 5", level); end
      resetn = 1'b0;
      #2;
      total++; if (level !== 5'd0 || rd_avail !== 1'b0 || full !== 1'b0 || overrun !== 1'b0 ||
                   break_det !== 1'b0 || irq_thresh !== 1'b0 || irq_timeout !== 1'b0) begin
         bad++; $display("FAIL reset_mid level=%0d avail=%b flags=%b%b%b%b%b want 0,0,00000",
                         level, rd_avail, full, overrun, break_det, irq_thresh, irq_timeout); end
      resetn = 1'b1;
      sb.delete();
      tick();
      total++; if (level !== 5'd0 || rd_avail !== 1'b0) begin
         bad++; $display("FAIL reset_release level=%0d avail=%b want 0/0", level, rd_avail); end
   endtask

   task automatic test_order();
      logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
         push_byte(vals[i]);
         if (i == 0) begin
            total++; if (rd_avail !== 1'b1 || rd_data !== 8'h11) begin
               bad++; $display("FAIL order_latency avail=%b data=%h want 1/11", rd_avail, rd_data); end
         end
      end
      for (int i = 0; i < 3; i++) begin
         pop_byte(got); exp = sb.pop_front();
         total++; if (got !== exp) begin
            bad++; $display("FAIL order_pop%0d got=%h want %h", i, got, exp); end
      end
      total++; if (rd_avail !== 1'b0) begin
         bad++; $display("FAIL order_empty avail=%b want 0", rd_avail); end
   endtask

   task automatic test_full_overrun();
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      total++; if (full !== 1'b1 || level !== 5'd16) begin
         bad++; $display("FAIL full_set full=%b level=%0d want 1/16", full, level); end
      push_byte(8'hAA);
      total++; if (overrun !== 1'b1 || level !== 5'd16) begin
         bad++; $display("FAIL overrun_set ovr=%b level=%0d want 1/16", overrun, level); end
      for (int i = 0; i < 16; i++) begin
         pop_byte(got); exp = sb.pop_front();
         total++; if (got !== exp) begin
            bad++; $display("FAIL full_pop%0d got=%h want %h", i, got, exp); end
      end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      total++; if (level !== 5'd0 || rd_avail !== 1'b0) begin
         bad++; $display("FAIL underflow level=%0d avail=%b want 0/0", level, rd_avail); end
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      total++; if (overrun !== 1'b0) begin
         bad++; $display("FAIL overrun_clr ovr=%b want 0", overrun); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
      exp = sb.pop_front();
      got = rd_data;
      sb.push_back(8'h55);
      rx_valid = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
      tick();
      rx_valid = 1'b0; rd_en = 1'b0;
      total++; if (got !== exp) begin
         bad++; $display("FAIL simul_head got=%h want %h", got, exp); end
      total++; if (level !== 5'd16 || overrun !== 1'b0) begin
         bad++; $display("FAIL simul_full level=%0d ovr=%b want 16/0", level, overrun); end
      for (int i = 0; i < 16; i++) begin
         pop_byte(got); exp = sb.pop_front();
         total++; if (got !== exp) begin
            bad++; $display("FAIL simul_pop%0d got=%h want %h", i, got, exp); end
      end
      rx_valid = 1'b1; rx_data = 8'h66; rd_en = 1'b1; sb.push_back(8'h66);
      tick();
      rx_valid = 1'b0; rd_en = 1'b0;
      total++; if (level !== 5'd1 || rd_data !== 8'h66) begin
         bad++; $display("FAIL simul_empty level=%0d data=%h want 1/66", level, rd_data); end
      rx_valid = 1'b1; rx_data = 8'h77; flush = 1'b1;
      tick();
      rx_valid = 1'b0; flush = 1'b0; sb.delete();
      total++; if (level !== 5'd0 || rd_avail !== 1'b0 || overrun !== 1'b0) begin
         bad++; $display("FAIL flush_push level=%0d avail=%b ovr=%b want 0/0/0", level, rd_avail, overrun); end
   endtask

   task automatic test_break_wrap();
      push_byte(8'h01);
      rx_valid = 1'b1; rx_break = 1'b1; rx_data = 8'h00;
      tick();
      rx_valid = 1'b0; rx_break = 1'b0;
      total++; if (break_det !== 1'b1 || level !== 5'd1) begin
         bad++; $display("FAIL break_set brk=%b level=%0d want 1/1", break_det, level); end
      rx_valid = 1'b1; rx_break = 1'b1; clr_flags = 1'b1;
      tick();
      rx_valid = 1'b0; rx_break = 1'b0; clr_flags = 1'b0;
      total++; if (break_det !== 1'b1) begin
         bad++; $display("FAIL break_prio brk=%b want 1", break_det); end
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      total++; if (break_det !== 1'b0) begin
         bad++; $display("FAIL break_clr brk=%b want 0", break_det); end
      flush = 1'b1; tick(); flush = 1'b0; sb.delete();
      for (int i = 0; i < 5; i++) push_byte(8'(i * 7 + 3));
      for (int i = 5; i < 40; i++) begin
         exp = sb.pop_front();
         got = rd_data;
         sb.push_back(8'(i * 7 + 3));
         rx_valid = 1'b1; rx_data = 8'(i * 7 + 3); rd_en = 1'b1;
         tick();
         rx_valid = 1'b0; rd_en = 1'b0;
         total++; if (got !== exp) begin
            bad++; $display("FAIL wrap_stream%0d got=%h want %h", i, got, exp); end
      end
      for (int i = 0; i < 5; i++) begin
         pop_byte(got); exp = sb.pop_front();
         total++; if (got !== exp) begin
            bad++; $display("FAIL wrap_drain%0d got=%h want %h", i, got, exp); end
      end
      total++; if (level !== 5'd0) begin
         bad++; $display("FAIL wrap_level level=%0d want 0", level); end
   endtask

   task automatic test_irq();
      thresh = 5'd4;
      for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i));
      total++; if (irq_thresh !== 1'b0) begin
         bad++; $display("FAIL thr_below irq=%b want 0", irq_thresh); end
      push_byte(8'hE3);
      total++; if (irq_thresh !== 1'b1) begin
         bad++; $display("FAIL thr_cross irq=%b want 1", irq_thresh); end
      pop_byte(got);
      total++; if (irq_thresh !== 1'b0) begin
         bad++; $display("FAIL thr_pop irq=%b want 0", irq_thresh); end
      thresh = 5'd17;
      for (int i = 0; i < 13; i++) push_byte(8'hF0);
      tick();
      total++; if (irq_thresh !== 1'b0 || level !== 5'd16) begin
         bad++; $display("FAIL thr_over irq=%b level=%0d want 0/16", irq_thresh, level); end
      thresh = 5'd0;
      flush = 1'b1; tick(); flush = 1'b0; sb.delete();
      to_limit = 16'd100;
      push_byte(8'h5A);
      for (int i = 0; i < 99; i++) tick();
      total++; if (irq_timeout !== 1'b0) begin
         bad++; $display("FAIL to_early irq=%b want 0", irq_timeout); end
      tick();
      total++; if (irq_timeout !== 1'b1) begin
         bad++; $display("FAIL to_fire irq=%b want 1", irq_timeout); end
      for (int i = 0; i < 5; i++) tick();
      total++; if (irq_timeout !== 1'b1) begin
         bad++; $display("FAIL to_hold irq=%b want 1", irq_timeout); end
      pop_byte(got); exp = sb.pop_front();
      total++; if (irq_timeout !== 1'b0 || got !== exp) begin
         bad++; $display("FAIL to_clear irq=%b data=%h want 0/%h", irq_timeout, got, exp); end
   endtask

   initial begin
      resetn = 1'b0; rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h00;
      rd_en = 1'b0; flush = 1'b0; clr_flags = 1'b0; thresh = 5'd0; to_limit = 16'd0;
      #12;
      test_reset();
      test_order();
      test_full_overrun();
      test_simultaneous();
      test_break_wrap();
      test_irq();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
